dram_rw_arbiter: RTL and testbench

Single-port DRAM arbiter for the camera-to-display frame buffer. It shares one Avalon-MM master port between two paths. The write path drains the D5M-side write FIFO into DRAM. The read path fetches DRAM words into the DVI-side read FIFO. Grants alternate round-robin in bursts of up to BURST_LEN words, and the arbiter generates wrapping frame addresses for both paths. It sits in the ctrl_clk domain between the two dual-clock FIFOs and the DRAM controller system.

---
 rtl/dram_rw_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dram_rw_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_rw_arbiter.sv
// Round-robin Avalon-MM arbiter between the frame-buffer write and read FIFOs.
// Optional ARB_FRAME_SYNC_EN: reads wait for the first completed write frame.
module dram_rw_arbiter #(
    parameter int unsigned FRAME_WORDS = 640,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned BURST_LEN   = 8,
    parameter int unsigned FIFO_DEPTH  = 512,
    parameter int unsigned READ_DELAY  = 64
) (
    input  logic        ctrl_clk,
    input  logic        reset_n,
    input  logic        wr_fifo_rdempty,
    output logic        wr_fifo_rdreq,
    input  logic [31:0] wr_fifo_q,
    input  logic [8:0]  rd_fifo_wrusedw,
    input  logic        rd_fifo_wrfull,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        wr_frame_done,
    output logic        rd_frame_done
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int DW = $clog2(READ_DELAY + 1);
    localparam logic [8:0]    RD_LIMIT = 9'(FIFO_DEPTH - 4);
    localparam logic [31:0]   LAST_IDX = 32'(FRAME_WORDS - 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);
    localparam logic [DW-1:0] DLY_LAST = DW'(READ_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_FETCH = 2'd1,
        WR_ISSUE = 2'd2,
        RD_ISSUE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_d;
    logic          prio_rd;
    logic          prio_d;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_nxt;
    logic          burst_more;
    logic [31:0]   wr_idx;
    logic [31:0]   rd_idx;
    logic [DW-1:0] dly_cnt;
    logic          dly_done;
    logic          rd_en;
    logic          wr_req;
    logic          rd_req;
    logic          wr_acc;
    logic          rd_acc;
    logic          wr_last;
    logic          rd_last;

`ifdef ARB_FRAME_SYNC_EN
    logic frame_seen;

    always_ff @(posedge ctrl_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_seen <= 1'b0;
        end else if (wr_frame_done) begin
            frame_seen <= 1'b1;
        end
    end

    assign rd_en = dly_done & frame_seen;
`else
    assign rd_en = dly_done;
`endif

    // Margin of 4 words absorbs the lag of the read FIFO's wrusedw.
    assign wr_req = ~wr_fifo_rdempty;
    assign rd_req = rd_en & ~rd_fifo_wrfull & (rd_fifo_wrusedw <= RD_LIMIT);

    assign wr_acc     = (state == WR_ISSUE) & ~avm_waitrequest;
    assign rd_acc     = (state == RD_ISSUE) & ~avm_waitrequest;
    assign burst_nxt  = burst_cnt + 1'b1;
    assign burst_more = burst_nxt < BURST_MAX;
    assign wr_last    = (wr_idx == LAST_IDX);
    assign rd_last    = (rd_idx == LAST_IDX);

    always_comb begin
        state_d       = state;
        prio_d        = prio_rd;
        wr_fifo_rdreq = 1'b0;
        avm_write     = 1'b0;
        avm_read      = 1'b0;
        case (state)
            IDLE: begin
                if (wr_req && (!rd_req || !prio_rd)) begin
                    state_d = WR_FETCH;
                end else if (rd_req) begin
                    state_d = RD_ISSUE;
                end
            end
            WR_FETCH: begin
                wr_fifo_rdreq = 1'b1;
                state_d       = WR_ISSUE;
            end
            WR_ISSUE: begin
                avm_write = 1'b1;
                if (!avm_waitrequest) begin
                    if (burst_more && wr_req) begin
                        state_d = WR_FETCH;
                    end else begin
                        state_d = IDLE;
                        prio_d  = 1'b1;
                    end
                end
            end
            RD_ISSUE: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    if (burst_more && rd_req) begin
                        state_d = RD_ISSUE;
                    end else begin
                        state_d = IDLE;
                        prio_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ctrl_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            prio_rd   <= 1'b0;
            burst_cnt <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            dly_cnt   <= '0;
            dly_done  <= 1'b0;
        end else begin
            state   <= state_d;
            prio_rd <= prio_d;
            if (state == IDLE) begin
                burst_cnt <= '0;
            end else if (wr_acc || rd_acc) begin
                burst_cnt <= burst_nxt;
            end
            if (wr_acc) begin
                wr_idx <= wr_last ? 32'd0 : wr_idx + 32'd1;
            end
            if (rd_acc) begin
                rd_idx <= rd_last ? 32'd0 : rd_idx + 32'd1;
            end
            if (!dly_done) begin
                if (dly_cnt == DLY_LAST) begin
                    dly_done <= 1'b1;
                end else begin
                    dly_cnt <= dly_cnt + 1'b1;
                end
            end
        end
    end

    // Bus outputs are gated by the strobes so an idle port drives zeros.
    always_comb begin
        avm_address   = 32'd0;
        avm_writedata = 32'd0;
        if (avm_write) begin
            avm_address   = BASE_ADDR + (wr_idx << 2);
            avm_writedata = wr_fifo_q;
        end else if (avm_read) begin
            avm_address = BASE_ADDR + (rd_idx << 2);
        end
    end

    assign rd_valid      = rd_acc;
    assign rd_data       = rd_acc ? avm_readdata : 32'd0;
    assign wr_frame_done = wr_acc & wr_last;
    assign rd_frame_done = rd_acc & rd_last;

endmodule

// File: tb/tb_dram_rw_arbiter.sv
// Directed bench for dram_rw_arbiter with FIFO and DRAM responders.
// Build with ARB_FRAME_SYNC_EN to exercise the frame-synchronised read start.
module tb_dram_rw_arbiter;

    logic        ctrl_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_fifo_rdempty;
    logic        wr_fifo_rdreq;
    logic [31:0] wr_fifo_q = 32'd0;
    logic [8:0]  rd_fifo_wrusedw = 9'd0;
    logic        rd_fifo_wrfull = 1'b1;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [31:0] avm_address;
    logic        avm_write;
    logic        avm_read;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest = 1'b0;
    logic        wr_frame_done;
    logic        rd_frame_done;

    dram_rw_arbiter dut (
        .ctrl_clk        (ctrl_clk),
        .reset_n         (reset_n),
        .wr_fifo_rdempty (wr_fifo_rdempty),
        .wr_fifo_rdreq   (wr_fifo_rdreq),
        .wr_fifo_q       (wr_fifo_q),
        .rd_fifo_wrusedw (rd_fifo_wrusedw),
        .rd_fifo_wrfull  (rd_fifo_wrfull),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_read        (avm_read),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .wr_frame_done   (wr_frame_done),
        .rd_frame_done   (rd_frame_done)
    );

    always #5 ctrl_clk = ~ctrl_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Stimulus-owned state
    int wf_pushed = 0;
    // Monitor-owned state
    int wf_popped = 0;
    int exp_widx = 0;
    int exp_ridx = 0;
    int n_wr = 0;
    int n_rd = 0;
    int n_rdreq = 0;
    int wfd_cnt = 0;
    int rfd_cnt = 0;
    int cyc = 0;
    int last_cyc = 0;
    int last_type = 0;
    bit w_pend = 0;
    bit r_pend = 0;
    logic [31:0] w_wrap_addr = '1;
    logic [31:0] w_post_addr = '1;
    logic [31:0] r_wrap_addr = '1;
    logic [31:0] r_post_addr = '1;
    logic [31:0] last_waddr = '1;
    int runs[$];

    assign wr_fifo_rdempty = (wf_pushed == wf_popped);
    assign avm_readdata = avm_address ^ 32'h5A5A_0000;

    function automatic int run_at(input int k);
        if (k < runs.size()) return runs[k];
        return 9999;
    endfunction

    // Negedge monitor: FIFO/DRAM responder plus per-transfer checks
    initial begin
        forever begin
            @(negedge ctrl_clk);
            cyc++;
            if (!reset_n) begin
                exp_widx = 0;
                exp_ridx = 0;
                last_type = 0;
                w_pend = 0;
                r_pend = 0;
            end else begin
                if (avm_read || avm_write)
                    chk("excl", 32'(avm_read & avm_write), 32'd0);
                if (rd_valid || avm_read)
                    chk("rd_valid", 32'(rd_valid),
                        32'(avm_read && !avm_waitrequest));
                if (wr_frame_done) wfd_cnt++;
                if (rd_frame_done) rfd_cnt++;
                if (wr_fifo_rdreq) begin
                    n_rdreq++;
                    if (wf_popped == wf_pushed) begin
                        chk("wf_underflow", 32'(wf_popped), 32'(wf_pushed - 1));
                    end else begin
                        wr_fifo_q = 32'hD000_0000 + 32'(wf_popped);
                        wf_popped++;
                    end
                end
                if (avm_write && !avm_waitrequest) begin
                    chk("wr_addr", avm_address, 32'(exp_widx) * 4);
                    chk("wr_data", avm_writedata, 32'hD000_0000 + 32'(n_wr));
                    chk("wr_fdone", 32'(wr_frame_done), 32'(exp_widx == 639));
                    last_waddr = avm_address;
                    if (w_pend) begin
                        w_post_addr = avm_address;
                        w_pend = 0;
                    end
                    if (exp_widx == 639) begin
                        w_wrap_addr = avm_address;
                        w_pend = 1;
                        exp_widx = 0;
                    end else exp_widx++;
                    if (last_type != 1 || cyc - last_cyc != 2) runs.push_back(1);
                    else runs[runs.size()-1] = runs[runs.size()-1] + 1;
                    last_type = 1;
                    last_cyc = cyc;
                    n_wr++;
                end
                if (avm_read && !avm_waitrequest) begin
                    chk("rd_addr", avm_address, 32'(exp_ridx) * 4);
                    chk("rd_data", rd_data,
                        (32'(exp_ridx) * 4) ^ 32'h5A5A_0000);
                    chk("rd_fdone", 32'(rd_frame_done), 32'(exp_ridx == 639));
                    if (r_pend) begin
                        r_post_addr = avm_address;
                        r_pend = 0;
                    end
                    if (exp_ridx == 639) begin
                        r_wrap_addr = avm_address;
                        r_pend = 1;
                        exp_ridx = 0;
                    end else exp_ridx++;
                    if (last_type != 2 || cyc - last_cyc != 1) runs.push_back(-1);
                    else runs[runs.size()-1] = runs[runs.size()-1] - 1;
                    last_type = 2;
                    last_cyc = cyc;
                    n_rd++;
                end
            end
        end
    end

    task automatic tick;
        @(posedge ctrl_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int r0;
        int n;
        logic [31:0] exp_runs [6];
        exp_runs[0] = -32'sd8;
        exp_runs[1] = 32'd8;
        exp_runs[2] = -32'sd8;
        exp_runs[3] = 32'd8;
        exp_runs[4] = -32'sd8;
        exp_runs[5] = 32'd8;

        repeat (3) tick;
        chk("rst_write", 32'(avm_write), 32'd0);
        chk("rst_read", 32'(avm_read), 32'd0);
        chk("rst_addr", avm_address, 32'd0);
        chk("rst_wdata", avm_writedata, 32'd0);
        chk("rst_rdreq", 32'(wr_fifo_rdreq), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_fdone", 32'({wr_frame_done, rd_frame_done}), 32'd0);
        reset_n = 1'b1;
        tick;
        tick;

        // Write-only, 20 words: bursts 8/8/4
        wf_pushed = 20;
        tick;
        chk("lat_rdreq", 32'(wr_fifo_rdreq), 32'd1);
        chk("lat_write_early", 32'(avm_write), 32'd0);
        tick;
        chk("lat_write", 32'(avm_write), 32'd1);
        for (int i = 0; i < 100 && n_wr < 20; i++) tick;
        repeat (4) tick;
        chk("wo_nwr", 32'(n_wr), 32'd20);
        chk("wo_rdreq", 32'(n_rdreq), 32'd20);
        chk("wo_last_addr", last_waddr, 32'h4C);
        chk("wo_runs", 32'(runs.size()), 32'd3);
        chk("wo_run0", 32'(run_at(0)), 32'd8);
        chk("wo_run1", 32'(run_at(1)), 32'd8);
        chk("wo_run2", 32'(run_at(2)), 32'd4);

        // Waitrequest stall during WR_ISSUE
        avm_waitrequest = 1'b1;
        wf_pushed = 21;
        for (int i = 0; i < 10 && !avm_write; i++) tick;
        chk("stall_start", 32'(avm_write), 32'd1);
        repeat (5) begin
            tick;
            chk("stall_write", 32'(avm_write), 32'd1);
            chk("stall_addr", avm_address, 32'h50);
            chk("stall_data", avm_writedata, 32'hD000_0014);
        end
        chk("stall_rdreq", 32'(n_rdreq), 32'd21);
        chk("stall_nwr", 32'(n_wr), 32'd20);
        avm_waitrequest = 1'b0;
        tick;
        tick;
        chk("stall_done", 32'(n_wr), 32'd21);

        // Write frame wrap at word 639
        wf_pushed = 641;
        for (int i = 0; i < 3000 && n_wr < 641; i++) tick;
        repeat (4) tick;
        chk("wwrap_nwr", 32'(n_wr), 32'd641);
        chk("wwrap_pulses", 32'(wfd_cnt), 32'd1);
        chk("wwrap_addr", w_wrap_addr, 32'h9FC);
        chk("wwrap_next", w_post_addr, 32'h0);

        // Both paths requesting; priority currently favours read
        base = runs.size();
        rd_fifo_wrusedw = 9'd0;
        rd_fifo_wrfull = 1'b0;
        wf_pushed = 665;
        for (int i = 0; i < 500 && n_wr < 665; i++) tick;
        rd_fifo_wrfull = 1'b1;
        repeat (12) tick;
        for (int k = 0; k < 6; k++)
            chk($sformatf("rr_run%0d", k), 32'(run_at(base + k)), exp_runs[k]);

        // Read FIFO fill thresholds
        r0 = n_rd;
        rd_fifo_wrusedw = 9'd509;
        rd_fifo_wrfull = 1'b0;
        repeat (10) tick;
        chk("usedw509_idle", 32'(n_rd - r0), 32'd0);
        rd_fifo_wrusedw = 9'd508;
        for (int i = 0; i < 20 && !avm_read; i++) tick;
        chk("usedw508_read", 32'(avm_read), 32'd1);
        rd_fifo_wrusedw = 9'd509;
        repeat (5) tick;
        chk("usedw509_stop", 32'(n_rd - r0), 32'd1);
        r0 = n_rd;
        rd_fifo_wrusedw = 9'd0;
        rd_fifo_wrfull = 1'b1;
        repeat (10) tick;
        chk("wrfull_idle", 32'(n_rd - r0), 32'd0);
        rd_fifo_wrfull = 1'b0;
        for (int i = 0; i < 20 && !avm_read; i++) tick;
        rd_fifo_wrfull = 1'b1;
        repeat (5) tick;
        chk("wrfull_stop", 32'(n_rd - r0), 32'd1);

        // Read frame wrap
        rd_fifo_wrfull = 1'b0;
        for (int i = 0; i < 1500 && rfd_cnt < 1; i++) tick;
        repeat (3) tick;
        rd_fifo_wrfull = 1'b1;
        repeat (12) tick;
        chk("rwrap_pulses", 32'(rfd_cnt), 32'd1);
        chk("rwrap_addr", r_wrap_addr, 32'h9FC);
        chk("rwrap_next", r_post_addr, 32'h0);

        // Reset in the middle of a stalled read
        avm_waitrequest = 1'b1;
        rd_fifo_wrfull = 1'b0;
        for (int i = 0; i < 20 && !avm_read; i++) tick;
        chk("pre_rst_read", 32'(avm_read), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_read", 32'(avm_read), 32'd0);
        chk("arst_write", 32'(avm_write), 32'd0);
        chk("arst_addr", avm_address, 32'd0);
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        chk("arst_rd_data", rd_data, 32'd0);
        avm_waitrequest = 1'b0;
        tick;
        tick;
        r0 = n_rd;
        reset_n = 1'b1;
`ifdef ARB_FRAME_SYNC_EN
        repeat (100) tick;
        chk("sync_no_read", 32'(n_rd - r0), 32'd0);
        wf_pushed = wf_pushed + 640;
        for (int i = 0; i < 3000 && !avm_read; i++) tick;
        chk("sync_read", 32'(avm_read), 32'd1);
        chk("sync_read_addr", avm_address, 32'd0);
        chk("sync_fdone", 32'(wfd_cnt), 32'd2);
`else
        n = 0;
        while (n < 200 && !avm_read) begin
            tick;
            n++;
        end
        chk("rd_delay_window", 32'(n >= 64 && n <= 66), 32'd1);
        chk("rd_resume_addr", avm_address, 32'd0);
`endif
        repeat (5) tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
